// File: rtl/ysyx_22050019_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_22050019_axi_sram
//   Single-beat AXI-lite-style memory responder used as the main-memory
//   endpoint for the cache refill/writeback path. One transaction is in
//   flight at a time. Read data and write responses appear LATENCY cycles
//   after the address (read) or data (write) handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ar_valid_i/ar_ready_o    read address handshake, ar_addr_i byte address
//   r_valid_o/r_ready_i      read data handshake, r_data_o, r_resp_o
//   aw_valid_i/aw_ready_o    write address handshake, aw_addr_i byte address
//   w_valid_i/w_ready_o      write data handshake, w_data_i, w_strb_i
//   b_valid_o/b_ready_i      write response handshake, b_resp_o
//   Responses: 2'b00 OKAY, 2'b10 SLVERR (address outside the array).
// ---------------------------------------------------------------------------
module ysyx_22050019_axi_sram #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [1:0]              r_resp_o,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  output logic [1:0]              b_resp_o
);

  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam int          DEPTH  = 2 ** MEM_AW;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam bit          LAT0   = (LATENCY == 0);
  // The counter is loaded one below LATENCY because the cycle that sees
  // cnt==0 also performs the load of the response registers; this places
  // the first valid cycle exactly LATENCY cycles after the wait begins.
  localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_R,
    S_W,
    S_BWAIT,
    S_B
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ar_hs, aw_hs, w_hs;
  logic                    ld_r, ld_b;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0]   rd_data;

  // True when the byte address falls inside [BASE_ADDR, BASE_ADDR + DEPTH*8).
  // The extra top bit catches addresses below the base as a borrow.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[ADDR_WIDTH] && ((off[ADDR_WIDTH-1:0] >> (MEM_AW + 3)) == '0);
  endfunction

  // Word index inside the array; the byte offset within a word is dropped.
  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return MEM_AW'(off >> 3);
  endfunction

  assign ar_ready_o = (state_q == S_IDLE);
  // Reads take priority over writes arriving in the same cycle.
  assign aw_ready_o = (state_q == S_IDLE) && !ar_valid_i;

  assign ar_hs = ar_valid_i && ar_ready_o;
  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = (state_q == S_W) && w_valid_i && w_ready_o;

  // With zero latency the read data is loaded at the AR handshake itself,
  // so the incoming address must be used instead of the latched one.
  assign rd_addr = (state_q == S_IDLE) ? ar_addr_i : req_addr_q;
  assign rd_ok   = in_range(rd_addr);
  assign rd_data = rd_ok ? mem[word_idx(rd_addr)] : '0;
  assign wr_ok   = in_range(req_addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_r    = 1'b0;
    ld_b    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          if (LAT0) begin
            state_d = S_R;
            ld_r    = 1'b1;
          end else begin
            state_d = S_RWAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (aw_hs) begin
          state_d = S_W;
        end
      end
      S_RWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_R;
          ld_r    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_R: begin
        if (r_ready_i) state_d = S_IDLE;
      end
      S_W: begin
        if (w_hs) begin
          if (LAT0) begin
            state_d = S_B;
            ld_b    = 1'b1;
          end else begin
            state_d = S_BWAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_BWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_B;
          ld_b    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_B: begin
        if (b_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_resp_o  <= '0;
      w_ready_o <= 1'b0;
      b_valid_o <= 1'b0;
      b_resp_o  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (ld_r) begin
        r_valid_o <= 1'b1;
        r_data_o  <= rd_data;
        r_resp_o  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if ((state_q == S_R) && r_ready_i) begin
        r_valid_o <= 1'b0;
      end

      if (aw_hs) begin
        w_ready_o <= 1'b1;
      end else if (w_hs) begin
        w_ready_o <= 1'b0;
      end

      if (ld_b) begin
        b_valid_o <= 1'b1;
        b_resp_o  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if ((state_q == S_B) && b_ready_i) begin
        b_valid_o <= 1'b0;
      end
    end
  end

  // Request address, latched at whichever address handshake opens the
  // transaction.
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      req_addr_q <= ar_addr_i;
    end else if (aw_hs) begin
      req_addr_q <= aw_addr_i;
    end
  end

  // Byte-masked array write at the W handshake. A reset in the same cycle
  // abandons the write so a transaction is either fully committed or not.
  always_ff @(posedge clk) begin
    if (w_hs && wr_ok && !rst) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (w_strb_i[k]) mem[word_idx(req_addr_q)][k*8 +: 8] <= w_data_i[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
module tb_ysyx_22050019_axi_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid, r_ready;
  logic [1:0]  r_resp;
  logic [63:0] r_data;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready;
  logic [7:0]  w_strb;
  logic [63:0] w_data;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_sram dut (
    .clk        (clk),
    .rst        (rst),
    .ar_valid_i (ar_valid),
    .ar_ready_o (ar_ready),
    .ar_addr_i  (ar_addr),
    .r_valid_o  (r_valid),
    .r_ready_i  (r_ready),
    .r_resp_o   (r_resp),
    .r_data_o   (r_data),
    .aw_valid_i (aw_valid),
    .aw_ready_o (aw_ready),
    .aw_addr_i  (aw_addr),
    .w_valid_i  (w_valid),
    .w_ready_o  (w_ready),
    .w_strb_i   (w_strb),
    .w_data_i   (w_data),
    .b_valid_o  (b_valid),
    .b_ready_i  (b_ready),
    .b_resp_o   (b_resp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Wait (at negedges) for the R beat, count cycles after the AR handshake,
  // then complete the handshake.
  task automatic r_phase(output logic [63:0] d, output logic [1:0] rs, output int lat);
    lat = 1;
    while (!r_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    d  = r_data;
    rs = r_resp;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  // Entered at the negedge following the AW handshake.
  task automatic w_phase(input logic [63:0] d, input logic [7:0] s,
                         output logic [1:0] rs, output int lat);
    int n;
    w_valid = 1'b1; w_data = d; w_strb = s;
    #1;
    n = 0;
    while (!w_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    lat = 1;
    while (!b_valid && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    rs = b_resp;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d,
                         output logic [1:0] rs, output int lat);
    int n;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = a;
    #1;
    n = 0;
    while (!ar_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    ar_valid = 1'b0;
    #1;
    r_phase(d, rs, lat);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] rs, output int lat);
    int n;
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = a;
    #1;
    n = 0;
    while (!aw_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    aw_valid = 1'b0;
    w_phase(d, s, rs, lat);
  endtask

  initial begin
    logic [63:0] d, hold;
    logic [1:0]  rs;
    int          lat;

    rst = 1'b1;
    ar_valid = 0; ar_addr = 0; r_ready = 0;
    aw_valid = 0; aw_addr = 0; w_valid = 0; w_strb = 0; w_data = 0; b_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_b_resp", b_resp, 0);

    // W before AW is not accepted
    w_valid = 1'b1;
    @(negedge clk); #1;
    chk("early_w_ready", w_ready, 0);
    w_valid = 1'b0;

    // Full write then read, latency 2
    do_write(32'h8000_0008, 64'h1122334455667788, 8'hff, rs, lat);
    chk("wr1_bresp", rs, 2'b00);
    chk("wr1_blat", lat, 3);
    do_read(32'h8000_0008, d, rs, lat);
    chk("rd1_data", d, 64'h1122334455667788);
    chk("rd1_resp", rs, 2'b00);
    chk("rd1_lat", lat, 3);

    // Partial write
    do_write(32'h8000_0008, 64'hAAAAAAAA_BBBBBBBB, 8'h0f, rs, lat);
    chk("wr2_bresp", rs, 2'b00);
    do_read(32'h8000_0008, d, rs, lat);
    chk("rd2_data", d, 64'h11223344_BBBBBBBB);

    // Byte offset bits ignored
    do_read(32'h8000_000F, d, rs, lat);
    chk("rd_offs_data", d, 64'h11223344_BBBBBBBB);

    // AR and AW together: read wins
    do_write(32'h8000_0000, 64'h0123456789ABCDEF, 8'hff, rs, lat);
    @(negedge clk);
    ar_valid = 1; ar_addr = 32'h8000_0008;
    aw_valid = 1; aw_addr = 32'h8000_0010;
    #1;
    chk("both_ar_ready", ar_ready, 1);
    chk("both_aw_ready", aw_ready, 0);
    @(negedge clk);
    ar_valid = 0;
    #1;
    chk("both_aw_ready_busy", aw_ready, 0);
    r_phase(d, rs, lat);
    chk("both_rdata", d, 64'h11223344_BBBBBBBB);
    chk("both_rresp", rs, 2'b00);
    #1;
    chk("both_aw_ready_after", aw_ready, 1);
    @(negedge clk);
    aw_valid = 0;
    w_phase(64'hCAFEF00D_DEADBEEF, 8'hff, rs, lat);
    chk("both_bresp", rs, 2'b00);
    do_read(32'h8000_0010, d, rs, lat);
    chk("both_readback", d, 64'hCAFEF00D_DEADBEEF);

    // Out of range
    do_read(32'h7FFF_FFF8, d, rs, lat);
    chk("oor_rresp", rs, 2'b10);
    chk("oor_rdata", d, 64'h0);
    do_write(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hff, rs, lat);
    chk("oor_bresp", rs, 2'b10);
    do_read(32'h8000_0000, d, rs, lat);
    chk("oor_unchanged", d, 64'h0123456789ABCDEF);

    // Last in-range word
    do_write(32'h8000_7FF8, 64'h5A5A_0000_A5A5_FFFF, 8'hff, rs, lat);
    chk("top_bresp", rs, 2'b00);
    do_read(32'h8000_7FF8, d, rs, lat);
    chk("top_rdata", d, 64'h5A5A_0000_A5A5_FFFF);
    chk("top_rresp", rs, 2'b00);

    // Backpressure on R
    @(negedge clk);
    ar_valid = 1; ar_addr = 32'h8000_0010;
    @(negedge clk);
    ar_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("bp_valid_first", r_valid, 1);
    hold = r_data;
    chk("bp_data_first", hold, 64'hCAFEF00D_DEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_r_valid", r_valid, 1);
      chk("bp_r_data", r_data, hold);
      chk("bp_ar_ready", ar_ready, 0);
    end
    r_ready = 1;
    @(negedge clk);
    r_ready = 0;
    #1;
    chk("bp_r_valid_done", r_valid, 0);
    chk("bp_ar_ready_done", ar_ready, 1);

    // Reset in S_BWAIT
    @(negedge clk);
    aw_valid = 1; aw_addr = 32'h8000_0018;
    @(negedge clk);
    aw_valid = 0;
    w_valid = 1; w_data = 64'h0BAD_C0DE_1234_5678; w_strb = 8'hff;
    @(negedge clk);
    w_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rstb_b_valid", b_valid, 0);
    chk("rstb_ar_ready", ar_ready, 1);
    chk("rstb_w_ready", w_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rstb_b_valid_later", b_valid, 0);
    do_read(32'h8000_0018, d, rs, lat);
    chk("rstb_committed", d, 64'h0BAD_C0DE_1234_5678);

    // Zero strobe: legal no-op
    do_write(32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, rs, lat);
    chk("strb0_bresp", rs, 2'b00);
    do_read(32'h8000_0008, d, rs, lat);
    chk("strb0_data", d, 64'h11223344_BBBBBBBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
